div_iter: RTL and testbench

Parametrised iterative integer divide unit for the MDU pipe. It executes the RV64M/RV32M divide and remainder ops (DIV/DIVU/REM/REMU and the W forms DIVW/DIVUW/REMW/REMUW) using radix-2 restoring division, one quotient bit per cycle. It uses the package `mdu_op_t` encoding, valid/ready handshakes on issue and writeback, and a tag passthrough. Divide-by-zero, signed overflow and the W-width path are handled here rather than upstream.

---
 rtl/div_iter.sv | 218 +++++++++++++++++++++
 tb/tb_div_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
//------------------------------------------------------------------------------
// Module   : div_iter
// Purpose  : Iterative radix-2 restoring divider for RV64M/RV32M DIV/REM ops
//            (incl. W forms) with valid/ready issue/writeback and tag passthru.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_iter #(
    parameter int XLEN      = 64,
    parameter int SUPPORT_W = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [3:0]           issue_op,
    input  logic [XLEN-1:0]      issue_A,
    input  logic [XLEN-1:0]      issue_B,
    input  logic [TAG_WIDTH-1:0] issue_tag,
    input  logic                 kill,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [XLEN-1:0]      wb_data,
    output logic [TAG_WIDTH-1:0] wb_tag
);

    localparam bit              c_W_EN  = (XLEN == 64) && (SUPPORT_W != 0);
    localparam int              c_CW    = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_MIN_X = XLEN'(1) << (XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN_W = ~(XLEN'(32'h7FFF_FFFF));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state_q, w_state_d;
    logic [c_CW-1:0]        r_cnt_q, w_cnt_d;
    logic [XLEN-1:0]        r_rem_q, w_rem_d;
    logic [XLEN-1:0]        r_quo_q, w_quo_d;
    logic [XLEN-1:0]        r_dvs_q, w_dvs_d;
    logic                   r_qneg_q, w_qneg_d;
    logic                   r_rneg_q, w_rneg_d;
    logic                   r_is_rem_q, w_is_rem_d;
    logic                   r_is_w_q, w_is_w_d;
    logic                   r_wb_valid_q, w_wb_valid_d;
    logic [XLEN-1:0]        r_wb_data_q, w_wb_data_d;
    logic [TAG_WIDTH-1:0]   r_wb_tag_q, w_wb_tag_d;

    logic                   w_accept, w_is_w, w_uns, w_rem, w_div_fam;
    logic [XLEN-1:0]        w_a_sx, w_a_zx, w_b_sx, w_b_zx;
    logic [XLEN-1:0]        w_a, w_b, w_a_mag, w_b_mag;
    logic                   w_sa, w_sb, w_dz, w_ovf;
    logic [XLEN-1:0]        w_special;
    logic [XLEN:0]          w_rem_sh, w_diff;
    logic                   w_qbit;
    logic [XLEN-1:0]        w_fix_sel, w_fix_val, w_fix_sx;
    logic                   w_fix_neg;

    assign issue_ready = (r_state_q == IDLE) & ~kill & ~RST;
    assign w_accept    = issue_valid & issue_ready;

    assign w_is_w    = issue_op[3] & c_W_EN;
    assign w_div_fam = issue_op[2];
    assign w_rem     = issue_op[1];
    assign w_uns     = issue_op[0];

    // 32-bit extension is only meaningful on a 64-bit datapath.
    generate
        if (XLEN > 32) begin : g_wide
            assign w_a_sx   = {{(XLEN-32){issue_A[31]}}, issue_A[31:0]};
            assign w_a_zx   = {{(XLEN-32){1'b0}},        issue_A[31:0]};
            assign w_b_sx   = {{(XLEN-32){issue_B[31]}}, issue_B[31:0]};
            assign w_b_zx   = {{(XLEN-32){1'b0}},        issue_B[31:0]};
            assign w_fix_sx = {{(XLEN-32){w_fix_val[31]}}, w_fix_val[31:0]};
        end else begin : g_narrow
            assign w_a_sx   = issue_A;
            assign w_a_zx   = issue_A;
            assign w_b_sx   = issue_B;
            assign w_b_zx   = issue_B;
            assign w_fix_sx = w_fix_val;
        end
    endgenerate

    assign w_a     = w_is_w ? (w_uns ? w_a_zx : w_a_sx) : issue_A;
    assign w_b     = w_is_w ? (w_uns ? w_b_zx : w_b_sx) : issue_B;
    assign w_sa    = ~w_uns & w_a[XLEN-1];
    assign w_sb    = ~w_uns & w_b[XLEN-1];
    assign w_a_mag = w_sa ? (~w_a + XLEN'(1)) : w_a;
    assign w_b_mag = w_sb ? (~w_b + XLEN'(1)) : w_b;
    assign w_dz    = (w_b == '0);
    assign w_ovf   = ~w_uns & (w_a == (w_is_w ? c_MIN_W : c_MIN_X)) & (&w_b);

    // Results that bypass the iteration; W remainder-by-zero is A[31:0] sign-extended.
    always_comb begin
        w_special = '0;
        if (w_div_fam) begin
            if (w_dz)
                w_special = w_rem ? (w_is_w ? w_a_sx : issue_A) : '1;
            else if (w_ovf)
                w_special = w_rem ? '0 : w_a;
        end
    end

    // One restoring step: the dividend streams out of the top of r_quo_q.
    assign w_rem_sh = {r_rem_q, r_quo_q[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs_q};
    assign w_qbit   = ~w_diff[XLEN];

    assign w_fix_sel = r_is_rem_q ? r_rem_q : r_quo_q;
    assign w_fix_neg = r_is_rem_q ? r_rneg_q : r_qneg_q;
    assign w_fix_val = w_fix_neg ? (~w_fix_sel + XLEN'(1)) : w_fix_sel;

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_rem_d      = r_rem_q;
        w_quo_d      = r_quo_q;
        w_dvs_d      = r_dvs_q;
        w_qneg_d     = r_qneg_q;
        w_rneg_d     = r_rneg_q;
        w_is_rem_d   = r_is_rem_q;
        w_is_w_d     = r_is_w_q;
        w_wb_valid_d = r_wb_valid_q;
        w_wb_data_d  = r_wb_data_q;
        w_wb_tag_d   = r_wb_tag_q;

        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    w_wb_tag_d = issue_tag;
                    w_is_rem_d = w_rem;
                    w_is_w_d   = w_is_w;
                    if (!w_div_fam || w_dz || w_ovf) begin
                        w_wb_data_d  = w_special;
                        w_wb_valid_d = 1'b1;
                        w_state_d    = DONE;
                    end else begin
                        w_dvs_d   = w_b_mag;
                        w_quo_d   = w_is_w ? (w_a_mag << (XLEN - 32)) : w_a_mag;
                        w_rem_d   = '0;
                        w_qneg_d  = w_sa ^ w_sb;
                        w_rneg_d  = w_sa;
                        w_cnt_d   = w_is_w ? c_CW'(31) : c_CW'(XLEN - 1);
                        w_state_d = ITER;
                    end
                end
            end
            ITER: begin
                w_rem_d = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                w_quo_d = {r_quo_q[XLEN-2:0], w_qbit};
                if (r_cnt_q == '0) begin
                    w_state_d = FIX;
                end else begin
                    w_cnt_d = r_cnt_q - c_CW'(1);
                end
            end
            FIX: begin
                w_wb_data_d  = r_is_w_q ? w_fix_sx : w_fix_val;
                w_wb_valid_d = 1'b1;
                w_state_d    = DONE;
            end
            DONE: begin
                if (wb_ready) begin
                    w_wb_valid_d = 1'b0;
                    w_state_d    = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase

        if (kill) begin
            w_state_d    = IDLE;
            w_wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q    <= IDLE;
            r_cnt_q      <= '0;
            r_rem_q      <= '0;
            r_quo_q      <= '0;
            r_dvs_q      <= '0;
            r_qneg_q     <= 1'b0;
            r_rneg_q     <= 1'b0;
            r_is_rem_q   <= 1'b0;
            r_is_w_q     <= 1'b0;
            r_wb_valid_q <= 1'b0;
            r_wb_data_q  <= '0;
            r_wb_tag_q   <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_rem_q      <= w_rem_d;
            r_quo_q      <= w_quo_d;
            r_dvs_q      <= w_dvs_d;
            r_qneg_q     <= w_qneg_d;
            r_rneg_q     <= w_rneg_d;
            r_is_rem_q   <= w_is_rem_d;
            r_is_w_q     <= w_is_w_d;
            r_wb_valid_q <= w_wb_valid_d;
            r_wb_data_q  <= w_wb_data_d;
            r_wb_tag_q   <= w_wb_tag_d;
        end
    end

    assign wb_valid = r_wb_valid_q;
    assign wb_data  = r_wb_data_q;
    assign wb_tag   = r_wb_tag_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
//------------------------------------------------------------------------------
// Module   : tb_div_iter
// Purpose  : Self-checking bench for div_iter (XLEN=64) against an arithmetic
//            reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_iter;

    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b0101;
    localparam logic [3:0] OP_REM   = 4'b0110;
    localparam logic [3:0] OP_REMU  = 4'b0111;
    localparam logic [3:0] OP_DIVW  = 4'b1100;
    localparam logic [3:0] OP_DIVUW = 4'b1101;
    localparam logic [3:0] OP_REMW  = 4'b1110;

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid, issue_ready;
    logic [3:0]  issue_op;
    logic [63:0] issue_A, issue_B;
    logic [3:0]  issue_tag;
    logic        kill;
    logic        wb_valid, wb_ready;
    logic [63:0] wb_data;
    logic [3:0]  wb_tag;

    int tests = 0;
    int fails = 0;

    div_iter #(.XLEN(64), .SUPPORT_W(1), .TAG_WIDTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_A(issue_A), .issue_B(issue_B),
        .issue_tag(issue_tag), .kill(kill),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_tag(wb_tag)
    );

    always #5 CLK = ~CLK;

    // RISC-V divide semantics from plain arithmetic on extended operands.
    function automatic logic [63:0] ref_div(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ae, be, res, mn;
        longint      sa, sb;
        if (!op[2]) return 64'd0;
        if (op[3]) begin
            ae = op[0] ? {32'd0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            be = op[0] ? {32'd0, b[31:0]} : {{32{b[31]}}, b[31:0]};
            mn = 64'hFFFF_FFFF_8000_0000;
        end else begin
            ae = a;
            be = b;
            mn = 64'h8000_0000_0000_0000;
        end
        if (be == 64'd0)
            res = op[1] ? ae : {64{1'b1}};
        else if (op[0])
            res = op[1] ? (ae % be) : (ae / be);
        else if (ae == mn && be == {64{1'b1}})
            res = op[1] ? 64'd0 : ae;
        else begin
            sa  = signed'(ae);
            sb  = signed'(be);
            res = op[1] ? 64'(sa % sb) : 64'(sa / sb);
        end
        if (op[3]) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] ae, be;
        if (!op[2]) return 1;
        ae = op[3] ? (op[0] ? {32'd0, a[31:0]} : {{32{a[31]}}, a[31:0]}) : a;
        be = op[3] ? (op[0] ? {32'd0, b[31:0]} : {{32{b[31]}}, b[31:0]}) : b;
        if (be == 64'd0) return 1;
        if (!op[0] && be == {64{1'b1}} &&
            ae == (op[3] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
        return op[3] ? 34 : 66;
    endfunction

    task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", nm, obs, exp);
        end
    endtask

    // Issue one op, wait for writeback, check latency/data/tag, then handshake.
    task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_d, input int exp_lat, input string nm);
        int         cyc;
        logic [3:0] tag;
        tag = 4'($urandom);
        @(negedge CLK);
        check({nm, " issue_ready"}, {63'd0, issue_ready}, 64'd1);
        issue_valid = 1'b1; issue_op = op; issue_A = a; issue_B = b; issue_tag = tag;
        @(posedge CLK);
        #1 issue_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (!wb_valid && cyc < 200);
        check({nm, " latency"}, 64'(cyc), 64'(exp_lat));
        check({nm, " data"}, wb_data, exp_d);
        check({nm, " tag"}, {60'd0, wb_tag}, {60'd0, tag});
        wb_ready = 1'b1;
        @(posedge CLK);
        #1 wb_ready = 1'b0;
        @(negedge CLK);
        check({nm, " ready after wb"}, {63'd0, issue_ready}, 64'd1);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return {64{1'b1}};
            2:       return 64'($urandom_range(1, 20));
            3:       return 64'h8000_0000_0000_0000;
            4:       return {32'($urandom_range(0, 1)), 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [3:0]  op, tag;
        logic [63:0] a, b, exp_d;
        int          cyc, seen;

        RST = 1'b1; issue_valid = 1'b0; issue_op = 4'd0; issue_A = '0; issue_B = '0;
        issue_tag = '0; kill = 1'b0; wb_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst issue_ready", {63'd0, issue_ready}, 64'd0);
        check("rst wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst wb_data", wb_data, 64'd0);
        check("rst wb_tag", {60'd0, wb_tag}, 64'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("ready after rst", {63'd0, issue_ready}, 64'd1);

        // Directed cases
        run_op(OP_DIVU, 64'd100, 64'd7, 64'd14, 66, "divu 100/7");
        run_op(OP_REMU, 64'd100, 64'd7, 64'd2, 66, "remu 100/7");
        run_op(OP_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, "div -7/2");
        run_op(OP_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "rem -7/2");
        run_op(OP_REM, 64'd7, -64'sd2, 64'd1, 66, "rem 7/-2");
        run_op(OP_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div by 0");
        run_op(OP_REMU, 64'd5, 64'd0, 64'd5, 1, "remu by 0");
        run_op(OP_REMW, 64'h1_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1, "remw by 0");
        run_op(OP_DIV, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000, 1, "div ovf");
        run_op(OP_REM, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'd0, 1, "rem ovf");
        run_op(OP_DIVW, 64'h8000_0000, {64{1'b1}}, 64'hFFFF_FFFF_8000_0000, 1, "divw ovf");
        run_op(OP_DIVUW, 64'h1_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34, "divuw");
        run_op(OP_DIVW, -64'sd9, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 34, "divw -9/4");
        run_op(4'b0010, 64'd9, 64'd3, 64'd0, 1, "illegal mul op");

        // Backpressure: result and tag hold while wb_ready is low
        a = {$urandom, $urandom}; b = 64'($urandom_range(3, 1000));
        exp_d = ref_div(OP_DIV, a, b); tag = 4'hA;
        @(negedge CLK);
        issue_valid = 1'b1; issue_op = OP_DIV; issue_A = a; issue_B = b; issue_tag = tag;
        @(posedge CLK);
        #1 issue_valid = 1'b0;
        cyc = 0;
        do begin @(negedge CLK); cyc++; end while (!wb_valid && cyc < 200);
        check("bp latency", 64'(cyc), 64'd66);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("bp data", wb_data, exp_d);
            check("bp tag", {60'd0, wb_tag}, {60'd0, tag});
            check("bp valid", {63'd0, wb_valid}, 64'd1);
            check("bp issue_ready", {63'd0, issue_ready}, 64'd0);
        end
        wb_ready = 1'b1;
        @(posedge CLK);
        #1 wb_ready = 1'b0;

        // Kill in cycle 20 of an op
        @(negedge CLK);
        issue_valid = 1'b1; issue_op = OP_DIVU; issue_A = 64'd1000; issue_B = 64'd3;
        @(posedge CLK);
        #1 issue_valid = 1'b0;
        repeat (20) @(negedge CLK);
        kill = 1'b1;
        @(posedge CLK);
        #1 kill = 1'b0;
        @(negedge CLK);
        check("kill ready c21", {63'd0, issue_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (wb_valid) seen++;
            @(negedge CLK);
        end
        check("kill no wb", 64'(seen), 64'd0);

        // Kill together with issue_valid in IDLE drops the op
        issue_valid = 1'b1; issue_op = OP_DIV; issue_A = 64'd5; issue_B = 64'd0; kill = 1'b1;
        #1 check("kill blocks ready", {63'd0, issue_ready}, 64'd0);
        @(posedge CLK);
        #1 begin issue_valid = 1'b0; kill = 1'b0; end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (wb_valid) seen++;
        end
        check("killed issue no wb", 64'(seen), 64'd0);
        check("killed issue idle", {63'd0, issue_ready}, 64'd1);

        // RST mid-op clears everything
        @(negedge CLK);
        issue_valid = 1'b1; issue_op = OP_DIVU; issue_A = 64'd77; issue_B = 64'd5;
        @(posedge CLK);
        #1 issue_valid = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("mid rst ready", {63'd0, issue_ready}, 64'd1);
        check("mid rst valid", {63'd0, wb_valid}, 64'd0);
        check("mid rst data", wb_data, 64'd0);

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            op = {1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) op[2] = 1'b0;
            a = rand_operand();
            b = rand_operand();
            run_op(op, a, b, ref_div(op, a, b), ref_lat(op, a, b), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
